digitizer_ctrl_axil: RTL and testbench

AXI4-Lite responder that implements the digitizer control/status register window at 0x6000_0000 (PS GP master side). It accepts single-beat register reads and writes from the processing system, and drives the capture datapath: start pulse, test-mode select and packet size. It also collects busy/done status back from that datapath. It terminates the PS initiator's write/read transactions; the capture stream then feeds the AXI DMA S2MM channel.

---
 rtl/digitizer_ctrl_axil.sv | 181 ++++++++++++++++++
 tb/tb_digitizer_ctrl_axil.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digitizer_ctrl_axil.sv
// rtl/digitizer_ctrl_axil.sv - AXI4-Lite control/status register window for the digitizer capture path
module digitizer_ctrl_axil #(
  parameter int          ADDR_W    = 4,
  parameter logic [31:0] PKT_RESET = 32'h0000_0100,
  parameter logic [31:0] VERSION   = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              start,
  output logic              test_mode,
  output logic [31:0]       pkt_size,
  input  logic              busy
);

  logic        aw_full_q, aw_full_d;
  logic [1:0]  aw_idx_q, aw_idx_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, start_d;
  logic        test_mode_q, test_mode_d;
  logic [31:0] pkt_q, pkt_d;
  logic        done_q, done_d;
  logic        rej_q, rej_d;
  logic        busy_dly_q;
  logic [31:0] pkt_merged;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic        unused_addr;

  // Ready signals come straight from state flops, never from the valids.
  assign s_axi_awready = !aw_full_q && !bvalid_q;
  assign s_axi_wready  = !w_full_q && !bvalid_q;
  assign s_axi_arready = !rvalid_q;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  // Both halves held: the write lands on this edge and the response goes out with it.
  assign commit        = aw_full_q && w_full_q;

  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign start         = start_q;
  assign test_mode     = test_mode_q;
  assign pkt_size      = pkt_q;

  // Only addr[3:2] selects a register; the remaining address bits are don't-care.
  assign unused_addr   = ^{s_axi_awaddr, s_axi_araddr};

  // Write channel: independent AW/W holding registers and the B response.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = s_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = s_axi_wdata;
        w_strb_d = s_axi_wstrb;
      end
      if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    end
  end

  // Register file update on commit; a busy falling edge sets DONE and wins over W1C.
  always_comb begin
    start_d     = 1'b0;
    test_mode_d = test_mode_q;
    pkt_d       = pkt_q;
    done_d      = done_q;
    rej_d       = rej_q;
    pkt_merged  = pkt_q;
    for (int b = 0; b < 4; b++) begin
      if (w_strb_q[b]) pkt_merged[8*b +: 8] = w_data_q[8*b +: 8];
    end
    if (commit) begin
      case (aw_idx_q)
        2'd0: if (w_strb_q[0]) begin
          test_mode_d = w_data_q[1];
          if (w_data_q[0]) begin
            if (busy) rej_d = 1'b1;
            else      start_d = 1'b1;
          end
        end
        2'd1: if (w_strb_q[0]) begin
          if (w_data_q[1]) done_d = 1'b0;
          if (w_data_q[2]) rej_d  = 1'b0;
        end
        2'd2: if (pkt_merged != 32'd0) pkt_d = pkt_merged;
        default: ;
      endcase
    end
    if (busy_dly_q && !busy) done_d = 1'b1;
  end

  // Read channel: capture the addressed register on the AR handshake and hold until taken.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (s_axi_araddr[3:2])
        2'd0:    rdata_d = {30'd0, test_mode_q, 1'b0};
        2'd1:    rdata_d = {29'd0, rej_q, done_q, busy};
        2'd2:    rdata_d = pkt_q;
        default: rdata_d = VERSION;
      endcase
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_full_q   <= 1'b0;
      aw_idx_q    <= 2'd0;
      w_full_q    <= 1'b0;
      w_data_q    <= 32'd0;
      w_strb_q    <= 4'd0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      start_q     <= 1'b0;
      test_mode_q <= 1'b0;
      pkt_q       <= PKT_RESET;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
      busy_dly_q  <= 1'b0;
    end else begin
      aw_full_q   <= aw_full_d;
      aw_idx_q    <= aw_idx_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      start_q     <= start_d;
      test_mode_q <= test_mode_d;
      pkt_q       <= pkt_d;
      done_q      <= done_d;
      rej_q       <= rej_d;
      busy_dly_q  <= busy;
    end
  end

endmodule

// File: tb/tb_digitizer_ctrl_axil.sv
// tb/tb_digitizer_ctrl_axil.sv - self-checking bench for digitizer_ctrl_axil
module tb_digitizer_ctrl_axil;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        start;
  logic        test_mode;
  logic [31:0] pkt_size;
  logic        busy = 1'b0;

  always #5 clk = ~clk;

  digitizer_ctrl_axil dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .start(start), .test_mode(test_mode), .pkt_size(pkt_size), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural register model
  logic [31:0] m_pkt;
  logic        m_tm, m_done, m_rej, m_start_exp;
  logic        prev_busy = 1'b0;
  logic        fell_now = 1'b0;
  int          exp_b = 0, got_b = 0, exp_starts = 0, got_starts = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt = 32'h0000_0100;
    m_tm = 1'b0;
    m_done = 1'b0;
    m_rej = 1'b0;
    m_start_exp = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {30'd0, m_tm, 1'b0};
      2'd1:    return {29'd0, m_rej, m_done, busy};
      2'd2:    return m_pkt;
      default: return 32'h0001_0000;
    endcase
  endfunction

  // Apply the effect of a write that has just been acknowledged.
  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] nv;
    case (a[3:2])
      2'd0: if (s[0]) begin
        m_tm = d[1];
        if (d[0]) begin
          if (busy) m_rej = 1'b1;
          else begin m_start_exp = 1'b1; exp_starts++; end
        end
      end
      2'd1: if (s[0]) begin
        if (d[1] && !fell_now) m_done = 1'b0;
        if (d[2]) m_rej = 1'b0;
      end
      2'd2: begin
        nv = m_pkt;
        for (int b = 0; b < 4; b++) if (s[b]) nv[8*b +: 8] = d[8*b +: 8];
        if (nv != 32'd0) m_pkt = nv;
      end
      default: ;
    endcase
  endtask

  // DONE is set whenever busy is seen high then low on consecutive edges.
  always @(posedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      fell_now = 1'b0;
    end else begin
      fell_now = prev_busy && !busy;
      if (fell_now) m_done = 1'b1;
      prev_busy = busy;
    end
  end

  // Per-cycle compare of the datapath controls against the model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        chk("pkt_size", pkt_size, m_pkt);
        chk("test_mode", {31'd0, test_mode}, {31'd0, m_tm});
        chk("start", {31'd0, start}, {31'd0, m_start_exp});
        if (start) got_starts++;
        if (s_axi_bvalid && s_axi_bready) got_b++;
      end
      m_start_exp = 1'b0;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly = 0, input int w_dly = 0, input int b_dly = 0,
                    input bit drop_busy = 0, input bit no_b = 0);
    bit aw_ok = 0;
    bit w_ok = 0;
    bit seen = 0;
    s_axi_awaddr = a;
    s_axi_wdata = d;
    s_axi_wstrb = s;
    for (int c = 0; c < 40 && !(aw_ok && w_ok); c++) begin
      @(negedge clk);
      s_axi_awvalid = !aw_ok && (c >= aw_dly);
      s_axi_wvalid = !w_ok && (c >= w_dly);
      #1;
      if (s_axi_awvalid && s_axi_awready) aw_ok = 1;
      if (s_axi_wvalid && s_axi_wready) w_ok = 1;
    end
    chk("aw_w_accept", {30'd0, aw_ok, w_ok}, 32'd3);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    if (drop_busy) busy = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = s_axi_bvalid;
    end
    chk("bvalid_rise", {31'd0, seen}, 32'd1);
    if (!seen) return;
    model_write(a, d, s);
    chk("bresp", {30'd0, s_axi_bresp}, 32'd0);
    if (no_b) return;
    for (int c = 0; c < b_dly; c++) begin
      @(negedge clk);
      chk("bvalid_hold", {31'd0, s_axi_bvalid}, 32'd1);
    end
    s_axi_bready = 1'b1;
    exp_b++;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("bvalid_drop", {31'd0, s_axi_bvalid}, 32'd0);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d, input int r_dly = 0);
    logic [31:0] first;
    @(negedge clk);
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    #1;
    chk("arready", {31'd0, s_axi_arready}, 32'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk("rvalid_rise", {31'd0, s_axi_rvalid}, 32'd1);
    chk("rresp", {30'd0, s_axi_rresp}, 32'd0);
    first = s_axi_rdata;
    for (int c = 0; c < r_dly; c++) begin
      @(negedge clk);
      chk("rdata_stable", s_axi_rdata, first);
      chk("rvalid_hold", {31'd0, s_axi_rvalid}, 32'd1);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("rvalid_drop", {31'd0, s_axi_rvalid}, 32'd0);
    d = first;
  endtask

  // Read and check against both a hand-computed literal and the model.
  task automatic rdchk(input string name, input logic [3:0] a, input logic [31:0] lit, input int r_dly = 0);
    logic [31:0] d;
    rd(a, d, r_dly);
    chk(name, d, lit);
    chk({name, "_model"}, d, m_read(a));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_awready", {31'd0, s_axi_awready}, 32'd1);
    chk("rst_wready", {31'd0, s_axi_wready}, 32'd1);
    chk("rst_arready", {31'd0, s_axi_arready}, 32'd1);
    chk("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_test_mode", {31'd0, test_mode}, 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset values
    rdchk("rst_ctrl", 4'h0, 32'h0);
    rdchk("rst_status", 4'h4, 32'h0);
    rdchk("rst_pkt", 4'h8, 32'h100);
    rdchk("rst_version", 4'hC, 32'h0001_0000);

    // Start sequence
    wr(4'h8, 32'h20, 4'hF);
    wr(4'h0, 32'h3, 4'hF);
    @(negedge clk);
    chk("start_pkt", pkt_size, 32'h20);
    chk("start_tm", {31'd0, test_mode}, 32'd1);
    chk("start_once", got_starts, 32'd1);
    rdchk("ctrl_after_start", 4'h0, 32'h2);

    // Done and write-1-clear
    busy = 1'b1;
    repeat (10) @(negedge clk);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    rdchk("done_set", 4'h4, 32'h2);
    wr(4'h4, 32'h2, 4'hF);
    rdchk("done_clr", 4'h4, 32'h0);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    wr(4'h4, 32'h2, 4'hF, 0, 0, 0, 1);
    rdchk("done_set_wins", 4'h4, 32'h2);
    wr(4'h4, 32'h2, 4'hF);
    rdchk("done_clr2", 4'h4, 32'h0);

    // Rejected start
    busy = 1'b1;
    repeat (2) @(negedge clk);
    wr(4'h0, 32'h1, 4'hF);
    rdchk("rej_status", 4'h4, 32'h5);
    wr(4'h4, 32'h4, 4'hF);
    rdchk("rej_clr", 4'h4, 32'h1);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    wr(4'h4, 32'h2, 4'hF);
    rdchk("status_idle", 4'h4, 32'h0);

    // Channel ordering and backpressure
    wr(4'h8, 32'h11, 4'hF, 3, 0, 5);
    rdchk("w_first", 4'h8, 32'h11);
    wr(4'h8, 32'h22, 4'hF, 0, 3, 5);
    rdchk("aw_first", 4'h8, 32'h22);
    wr(4'h8, 32'h33, 4'hF, 0, 0, 5);
    rdchk("rready_stall", 4'h8, 32'h33, 4);
    chk("b_count_mid", got_b, exp_b);

    // Edge cases
    wr(4'h8, 32'h0, 4'hF);
    rdchk("pkt_zero_ignored", 4'h8, 32'h33);
    wr(4'h8, 32'h20, 4'hF);
    wr(4'h8, 32'hAB00, 4'b0010);
    rdchk("pkt_strb", 4'h8, 32'hAB20);
    wr(4'hC, 32'h1234, 4'hF);
    rdchk("version_ro", 4'hC, 32'h0001_0000);
    wr(4'h0, 32'h3, 4'b1110);
    rdchk("ctrl_no_byte0", 4'h0, 32'h0);

    // Reset while a B response is pending
    wr(4'h8, 32'h55, 4'hF, 0, 0, 0, 0, 1);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_drops_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    do_reset();
    rdchk("rst2_pkt", 4'h8, 32'h100);
    rdchk("rst2_ctrl", 4'h0, 32'h0);
    rdchk("rst2_status", 4'h4, 32'h0);

    repeat (2) @(negedge clk);
    chk("b_count", got_b, exp_b);
    chk("start_count", got_starts, exp_starts);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
